// File: rtl/mycpu_mul.sv
// Iterative shift-and-add unsigned multiplier: one partial product per RUN cycle,
// DW cycles per operation, result and flags registered on entry to DONE.
module mycpu_mul #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] y,
    output logic          v,
    output logic          z,
    output logic          n
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [2*DW-1:0] mcand;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] acc_next;
    logic [DW-1:0]   mlr;
    logic [CW-1:0]   cnt;

    // On the final RUN cycle acc_next already holds the complete product.
    always_comb begin
        acc_next = acc;
        if (mlr[0]) begin
            acc_next = acc + mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            mcand <= '0;
            acc   <= '0;
            mlr   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
            v     <= 1'b0;
            z     <= 1'b0;
            n     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        mcand <= {{DW{1'b0}}, a};
                        mlr   <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mlr   <= mlr >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(DW - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        y     <= acc_next[DW-1:0];
                        v     <= |acc_next[2*DW-1:DW];
                        z     <= (acc_next[DW-1:0] == '0);
                        n     <= acc_next[DW-1];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mycpu_mul.sv
// Self-checking bench for mycpu_mul: directed scenarios plus randomized operations
// compared against a plain-arithmetic product model with fixed-latency timing.
module tb_mycpu_mul;

    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          busy;
    logic          done;
    logic [DW-1:0] y;
    logic          v;
    logic          z;
    logic          n;

    int checks = 0;
    int errors = 0;

    // Last completed result as the model sees it; held until the next completion.
    logic [DW-1:0] ey;
    logic          ev;
    logic          ez;
    logic          en;

    mycpu_mul #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .v     (v),
        .z     (z),
        .n     (n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_held(input string tag);
        chk(tag, 32'({y, v, z, n}), 32'({ey, ev, ez, en}));
    endtask

    // Issue one multiply; returns positioned in the done cycle with start low.
    task automatic run_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb_v,
                          input bit hold, input bit scramble);
        logic [31:0] p;
        p = 32'(ta) * 32'(tb_v);
        a = ta;
        b = tb_v;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        for (int i = 1; i <= DW; i++) begin
            if (scramble) begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk_held("result_held_run");
            step();
        end
        start = 1'b0;
        ey = p[15:0];
        ev = |p[31:16];
        ez = (p[15:0] == 16'h0000);
        en = p[15];
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("y", 32'(y), 32'(ey));
        chk("v", 32'(v), 32'(ev));
        chk("z", 32'(z), 32'(ez));
        chk("n", 32'(n), 32'(en));
    endtask

    task automatic idle_chk();
        step();
        chk("busy_idle", 32'(busy), 32'd0);
        chk("done_idle", 32'(done), 32'd0);
        chk_held("result_held_idle");
    endtask

    function automatic logic [DW-1:0] rand_operand();
        logic [DW-1:0] r;
        case ($urandom_range(0, 5))
            0:       r = '0;
            1:       r = '1;
            2:       r = 16'(1) << $urandom_range(0, DW - 1);
            default: r = 16'($urandom);
        endcase
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        ey = '0;
        ev = 1'b0;
        ez = 1'b0;
        en = 1'b0;

        // Reset state, with start asserted to confirm reset priority.
        step();
        start = 1'b1;
        a = 16'h1234;
        b = 16'h5678;
        step();
        chk("reset_outputs", 32'({busy, done, y, v, z, n}), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;

        // Basic product, first start right after reset release.
        run_op(16'd3, 16'd5, 1'b0, 1'b0);
        idle_chk();

        // Product wraps entirely into the high half.
        run_op(16'h0100, 16'h0100, 1'b0, 1'b0);
        idle_chk();

        // start held through RUN and operands changed mid-flight.
        run_op(16'hFFFF, 16'h0001, 1'b1, 1'b1);
        idle_chk();
        idle_chk();

        // Back-to-back: restart in the done cycle, first result held meanwhile.
        run_op(16'd3, 16'd5, 1'b0, 1'b0);
        run_op(16'd7, 16'd6, 1'b0, 1'b0);
        idle_chk();

        // Reset in RUN cycle 8 aborts the operation.
        a = 16'hABCD;
        b = 16'h0F0F;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 2; i <= 8; i++) step();
        chk("busy_before_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        chk("abort_outputs", 32'({busy, done, y, v, z, n}), 32'd0);
        rst_n = 1'b1;
        ey = '0;
        ev = 1'b0;
        ez = 1'b0;
        en = 1'b0;
        run_op(16'd2, 16'd2, 1'b0, 1'b0);
        idle_chk();

        // Randomized operations with random gaps, holds and operand churn.
        for (int k = 0; k < 30; k++) begin
            run_op(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) begin
                idle_chk();
            end
        end
        idle_chk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
